// File: rtl/bus_pkg.sv
// Shared widths, bus types and DMA sequencer state encoding.
package bus_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 16;

  typedef logic [DATA_WIDTH-1:0] bus_data_t;
  typedef logic [ADDR_WIDTH-1:0] bus_addr_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RD_T1 = 3'd2,
    RD_TW = 3'd3,
    WR_T1 = 3'd4,
    WR_TW = 3'd5,
    REL   = 3'd6
  } dma_state_e;

  // States in which the bus is ours and a dropped grant is a fault.
  function automatic logic owns_bus(input dma_state_e s);
    return (s == RD_T1) || (s == RD_TW) || (s == WR_T1) || (s == WR_TW);
  endfunction
endpackage

// File: rtl/bus_cycle_engine.sv
// Single read/write bus access: registered strobes/address for T1/TW,
// wait-line sampling and the read holding register.
module bus_cycle_engine #(
  parameter int DW = bus_pkg::DATA_WIDTH,
  parameter int AW = bus_pkg::ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  bus_pkg::dma_state_e ph_q_i,
  input  bus_pkg::dma_state_e ph_d_i,
  input  logic [AW-1:0]       src_d_i,
  input  logic [AW-1:0]       dst_d_i,
  input  logic                buswait_n_i,
  input  logic [DW-1:0]       rdata_i,
  output logic                acc_done_o,
  output logic                drv_o,
  output logic                drv_data_o,
  output logic [AW-1:0]       addr_o,
  output logic [DW-1:0]       wdata_o,
  output logic                mreq_n_o,
  output logic                rd_n_o,
  output logic                wr_n_o
);
  import bus_pkg::*;

  logic          is_rd, is_wr;
  logic          drv_q, drv_data_q, mreq_n_q, rd_n_q, wr_n_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] hold_q;

  assign is_rd      = (ph_d_i == RD_T1) || (ph_d_i == RD_TW);
  assign is_wr      = (ph_d_i == WR_T1) || (ph_d_i == WR_TW);
  assign acc_done_o = buswait_n_i && ((ph_q_i == RD_TW) || (ph_q_i == WR_TW));

  // Outputs are registered from the next phase so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      drv_q      <= 1'b0;
      drv_data_q <= 1'b0;
      mreq_n_q   <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      addr_q     <= '0;
      hold_q     <= '0;
    end else begin
      drv_q      <= is_rd || is_wr || (ph_d_i == REL);
      drv_data_q <= is_wr;
      mreq_n_q   <= !(is_rd || is_wr);
      rd_n_q     <= !is_rd;
      wr_n_q     <= !is_wr;
      addr_q     <= is_wr ? dst_d_i : src_d_i;
      if ((ph_q_i == RD_TW) && (ph_d_i == WR_T1)) hold_q <= rdata_i;
    end
  end

  assign drv_o      = drv_q;
  assign drv_data_o = drv_data_q;
  assign addr_o     = addr_q;
  assign wdata_o    = hold_q;
  assign mreq_n_o   = mreq_n_q;
  assign rd_n_o     = rd_n_q;
  assign wr_n_o     = wr_n_q;
endmodule

// File: rtl/bus_dma_master.sv
// Memory-to-memory DMA bus master: requests the bus, copies length bytes
// src->dst one read/write pair at a time, then releases the bus.
module bus_dma_master #(
  parameter int DATA_WIDTH = bus_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = bus_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  busrq_n,
  input  logic                  buack_n,
  output tri                    mreq_n,
  output tri                    iorq_n,
  output tri                    rd_n,
  output tri                    wr_n,
  output tri [ADDR_WIDTH-1:0]   addr,
  inout  tri [DATA_WIDTH-1:0]   data,
  input  logic                  buswait_n
);
  import bus_pkg::*;

  dma_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d;
  logic                  zero_len, abort, acc_done;
  logic                  drv, drv_data, e_mreq_n, e_rd_n, e_wr_n;
  logic [ADDR_WIDTH-1:0] e_addr;
  logic [DATA_WIDTH-1:0] e_wdata;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    zero_len = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (length != '0) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          cnt_d   = length;
          state_d = REQ;
        end else begin
          zero_len = 1'b1;
        end
      end
      REQ:   if (!buack_n) state_d = RD_T1;
      RD_T1: state_d = RD_TW;
      RD_TW: if (acc_done) state_d = WR_T1;
      WR_T1: state_d = WR_TW;
      WR_TW: if (acc_done) begin
        src_d   = src_q + ADDR_WIDTH'(1);
        dst_d   = dst_q + ADDR_WIDTH'(1);
        cnt_d   = cnt_q - ADDR_WIDTH'(1);
        state_d = (cnt_d != '0) ? RD_T1 : REL;
      end
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Losing the grant mid-transfer wins over any progress this cycle.
    if (owns_bus(state_q) && buack_n) begin
      state_d = IDLE;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      abort   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      busrq_n <= 1'b1;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d != IDLE);
      done    <= zero_len || (state_d == REL);
      error   <= abort;
      busrq_n <= !((state_d == REQ) || owns_bus(state_d));
    end
  end

  bus_cycle_engine #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_eng (
    .clk         (clk),
    .reset       (reset),
    .ph_q_i      (state_q),
    .ph_d_i      (state_d),
    .src_d_i     (src_d),
    .dst_d_i     (dst_d),
    .buswait_n_i (buswait_n),
    .rdata_i     (data),
    .acc_done_o  (acc_done),
    .drv_o       (drv),
    .drv_data_o  (drv_data),
    .addr_o      (e_addr),
    .wdata_o     (e_wdata),
    .mreq_n_o    (e_mreq_n),
    .rd_n_o      (e_rd_n),
    .wr_n_o      (e_wr_n)
  );

  // Data is only ever driven in write phases, so never while rd_n is low.
  assign addr   = drv      ? e_addr   : 'z;
  assign mreq_n = drv      ? e_mreq_n : 1'bz;
  assign iorq_n = drv      ? 1'b1     : 1'bz;
  assign rd_n   = drv      ? e_rd_n   : 1'bz;
  assign wr_n   = drv      ? e_wr_n   : 1'bz;
  assign data   = drv_data ? e_wdata  : 'z;
endmodule

// File: doc/bus_dma_master.md
BUS_DMA_MASTER -- requirements
Module: bus_dma_master

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, the bus data width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 16, the bus address and length width.
REQ-003 Port clk  input  1  is the single clock; every register updates on its rising edge.
REQ-004 Port reset  input  1  is a synchronous, active-high reset sampled on the rising edge of clk.
REQ-005 Port start  input  1  is a one-cycle pulse that launches a transfer; it is ignored while busy=1.
REQ-006 Ports src_addr, dst_addr, length  input  ADDR_WIDTH each  are the transfer source, destination and byte count, latched on start.
REQ-007 Port busy  output  1  is high from the accepted start until done or error.
REQ-008 Ports done and error  output  1 each  are one-cycle completion and failure pulses.
REQ-009 Port busrq_n  output  1  is the bus request, active low.
REQ-010 Port buack_n  input  1  is the bus grant, active low.
REQ-011 Ports mreq_n, iorq_n, rd_n, wr_n  output (tri-state)  1 each  are the bus strobes, active low.
REQ-012 Port addr  output (tri-state)  ADDR_WIDTH  is the bus address.
REQ-013 Port data  inout  DATA_WIDTH  is the shared bus data.
REQ-014 Port buswait_n  input  1  is the responder wait line; low stretches the current access.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ, RD_T1, RD_TW, WR_T1, WR_TW and REL.
REQ-016 IDLE: on start with length!=0, the block SHALL latch its inputs, set busy, and enter REQ; on start with length==0 it SHALL pulse done in the next cycle without touching busrq_n.
REQ-017 REQ: busrq_n SHALL be 0; the block SHALL wait for buack_n=0, then enter RD_T1 in the following cycle.
REQ-018 From RD_T1 until REL, the bus outputs SHALL be driven; in all other states addr, mreq_n, iorq_n, rd_n, wr_n and data SHALL be high-Z.
REQ-019 RD_T1: addr=src pointer, mreq_n=0, rd_n=0, wr_n=1, iorq_n=1, data=Z; the block SHALL then go to RD_TW.
REQ-020 RD_TW: strobes held; while buswait_n=0 the block SHALL stay; when buswait_n=1 it SHALL latch data into a holding register and go to WR_T1.
REQ-021 WR_T1: addr=dst pointer, mreq_n=0, wr_n=0, rd_n=1, data driven from the holding register; the block SHALL then go to WR_TW.
REQ-022 WR_TW: strobes held; while buswait_n=0 the block SHALL stay; when buswait_n=1 it SHALL increment both pointers and decrement the remaining count.
REQ-023 At the end of WR_TW, the block SHALL enter RD_T1 if the remaining count is nonzero, otherwise REL.
REQ-024 REL: strobes SHALL be 1 and driven for one cycle, busrq_n SHALL be 1, and done SHALL pulse; the block SHALL then enter IDLE with busy=0.
REQ-025 Each byte SHALL take at least 4 cycles: 2 for the read plus 2 for the write, plus one cycle per cycle of buswait_n=0.
REQ-026 Pointers SHALL wrap modulo 2^ADDR_WIDTH (FFFF+1 -> 0000); the count SHALL use ADDR_WIDTH bits, so the maximum transfer is 65535 bytes.
REQ-027 If buack_n rises in any bus-owning state, the block SHALL tri-state on the next cycle, deassert busrq_n, pulse error, and return to IDLE.
REQ-028 The block SHALL never drive data while rd_n=0.

Reset
REQ-029 Reset SHALL force IDLE; busrq_n=1; busy=done=error=0; bus outputs high-Z; pointers, count and holding register=0.
REQ-030 Reset asserted mid-transfer SHALL release the bus within the same edge, with no done or error pulse.

Structure
REQ-031 The shared package bus_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH, bus_data_t, bus_addr_t and the FSM state enum.
REQ-032 The sub-module bus_cycle_engine SHALL perform one read or write access (T1/TW plus wait sampling); bus_dma_master SHALL sequence it.

Verification
REQ-033 The bench SHALL cover: src=0010, dst=8020, len=3, grant after 2 cycles, no waits -> 3 reads at 0010-0012, 3 writes at 8020-8022 with matching data, done 1+12+1 cycles after grant.
REQ-034 The bench SHALL cover: len=1 with buswait_n=0 for 3 cycles on the read -> RD_TW lasts 4 cycles and the byte transfers intact.
REQ-035 The bench SHALL cover: len=0 -> done pulses one cycle after start and busrq_n never falls.
REQ-036 The bench SHALL cover: src=FFFF, len=2 -> reads at FFFF then 0000.
REQ-037 The bench SHALL cover: buack_n rising during WR_TW of byte 2 of 4 -> error pulse, bus high-Z next cycle, busy=0.
REQ-038 The bench SHALL cover: reset during RD_TW -> all bus outputs high-Z and busrq_n=1 after the edge, with no done pulse.
